btb_assoc: RTL and testbench

- Parametrised, N-way set-associative branch target buffer; successor to the direct-mapped, strong-bit BTB.
- IF stage presents the fetch PC and receives hit, direction prediction and target in the same cycle.
- EX stage returns the resolved outcome through an update port.
- Each entry holds a 2-bit saturating direction counter. Invalid-first then round-robin replacement, a flush input, and saturating statistics counters are built in.

---
 rtl/btb_assoc_if.sv | 41 ++++
 rtl/btb_assoc.sv | 139 +++++++++++++
 tb/tb_btb_assoc.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/btb_assoc_if.sv
// Fetch lookup, EX update, flush and statistics bundle for the set-associative BTB.
// master = pipeline side, slave = BTB.
interface btb_assoc_if #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned CNT_W = 16
);
  logic            lookup_en;
  logic [PC_W-1:0] lookup_pc;
  logic            hit;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;

  logic            upd_en;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            upd_hit;
  logic            upd_pred_taken;

  logic            flush;

  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] mispr_cnt;

  modport master (
    output lookup_en, lookup_pc,
    output upd_en, upd_pc, upd_taken, upd_target, upd_hit, upd_pred_taken,
    output flush,
    input  hit, pred_taken, pred_target,
    input  br_cnt, hit_cnt, mispr_cnt
  );

  modport slave (
    input  lookup_en, lookup_pc,
    input  upd_en, upd_pc, upd_taken, upd_target, upd_hit, upd_pred_taken,
    input  flush,
    output hit, pred_taken, pred_target,
    output br_cnt, hit_cnt, mispr_cnt
  );
endinterface

// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer with 2-bit direction counters,
// invalid-first/round-robin replacement, flush and saturating statistics.
module btb_assoc #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned SETS  = 256,
  parameter int unsigned WAYS  = 2,
  parameter int unsigned CNT_W = 16
) (
  input logic       clk,
  input logic       rst,
  btb_assoc_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = PC_W - IDX_W;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [SETS-1:0]  valid_q [WAYS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [1:0]       ctr_q   [WAYS][SETS];
  logic [PC_W-1:0]  tgt_q   [WAYS][SETS];
  logic [WAY_W-1:0] vp_q    [SETS];

  logic [CNT_W-1:0] br_q, hit_q, mispr_q;

  // Lookup side: combinational read of pre-edge contents.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_match, lk_dir, hit_c;
  logic [PC_W-1:0]  lk_tgt;

  assign lk_idx = bus.lookup_pc[IDX_W-1:0];
  assign lk_tag = bus.lookup_pc[PC_W-1:IDX_W];

  always_comb begin
    lk_match = 1'b0;
    lk_dir   = 1'b0;
    lk_tgt   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[w][lk_idx] && (tag_q[w][lk_idx] == lk_tag)) begin
        lk_match = 1'b1;
        lk_dir   = ctr_q[w][lk_idx][1];
        lk_tgt   = tgt_q[w][lk_idx];
      end
    end
    hit_c = bus.lookup_en & lk_match;
  end

  assign bus.hit         = hit_c;
  assign bus.pred_taken  = hit_c & lk_dir;
  assign bus.pred_target = hit_c ? lk_tgt : '0;

  // Update side: tag search is independent of the pipelined hit bit.
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_match, has_inv, stale, mispr_c;
  logic [WAY_W-1:0] match_way, inv_way, wr_way, vp_next;
  logic [1:0]       cur_ctr, new_ctr;
  logic             do_write, adv_vp;
  logic             unused_upd_hit;

  assign up_idx         = bus.upd_pc[IDX_W-1:0];
  assign up_tag         = bus.upd_pc[PC_W-1:IDX_W];
  assign unused_upd_hit = bus.upd_hit;

  always_comb begin
    up_match  = 1'b0;
    match_way = '0;
    has_inv   = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[w][up_idx] && (tag_q[w][up_idx] == up_tag)) begin
        up_match  = 1'b1;
        match_way = WAY_W'(w);
      end
      if (!has_inv && !valid_q[w][up_idx]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end

    if (up_match)     wr_way = match_way;
    else if (has_inv) wr_way = inv_way;
    else              wr_way = vp_q[up_idx];

    vp_next = (WAYS > 1) ? WAY_W'(vp_q[up_idx] + WAY_W'(1)) : '0;

    cur_ctr = ctr_q[match_way][up_idx];
    if (!up_match)         new_ctr = 2'b10;
    else if (bus.upd_taken) new_ctr = (cur_ctr == 2'b11) ? 2'b11 : 2'(cur_ctr + 2'd1);
    else                   new_ctr = (cur_ctr == 2'b00) ? 2'b00 : 2'(cur_ctr - 2'd1);

    // A vanished entry cannot confirm the predicted target, so it counts as stale.
    stale   = up_match ? (tgt_q[match_way][up_idx] != bus.upd_target) : 1'b1;
    mispr_c = bus.upd_en & ((bus.upd_pred_taken != bus.upd_taken) |
                            (bus.upd_pred_taken & bus.upd_taken & stale));

    do_write = bus.upd_en & ~bus.flush & (up_match | bus.upd_taken);
    adv_vp   = do_write & ~up_match & ~has_inv;
  end

  // Valid bits and victim pointers: the only entry state that needs reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int unsigned s = 0; s < SETS; s++) vp_q[s] <= '0;
    end else if (bus.flush) begin
      for (int unsigned w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int unsigned s = 0; s < SETS; s++) vp_q[s] <= '0;
    end else begin
      if (do_write) valid_q[wr_way][up_idx] <= 1'b1;
      if (adv_vp)   vp_q[up_idx] <= vp_next;
    end
  end

  // Entry payload; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (do_write && !rst) begin
      tag_q[wr_way][up_idx] <= up_tag;
      ctr_q[wr_way][up_idx] <= new_ctr;
      if (bus.upd_taken) tgt_q[wr_way][up_idx] <= bus.upd_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_q    <= '0;
      hit_q   <= '0;
      mispr_q <= '0;
    end else begin
      if (bus.upd_en && (br_q != '1))  br_q    <= br_q + CNT_W'(1);
      if (hit_c && (hit_q != '1))      hit_q   <= hit_q + CNT_W'(1);
      if (mispr_c && (mispr_q != '1))  mispr_q <= mispr_q + CNT_W'(1);
    end
  end

  assign bus.br_cnt    = br_q;
  assign bus.hit_cnt   = hit_q;
  assign bus.mispr_cnt = mispr_q;
endmodule

// File: tb/tb_btb_assoc.sv
// Scoreboard bench for btb_assoc: directed scenarios plus randomized traffic
// checked against a behavioural set/way model.
module tb_btb_assoc;
  localparam int unsigned PC_W  = 16;
  localparam int unsigned SETS  = 256;
  localparam int unsigned WAYS  = 2;
  localparam int unsigned CNT_W = 4;
  localparam int          MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  btb_assoc_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  btb_assoc #(.PC_W(PC_W), .SETS(SETS), .WAYS(WAYS), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          hit;
    bit          pt;
    logic [15:0] tgt;
    int          br;
    int          hc;
    int          mc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: each set is a list of WAYS slots with a round-robin pointer.
  bit          m_v   [WAYS][SETS];
  logic [7:0]  m_tag [WAYS][SETS];
  int          m_ctr [WAYS][SETS];
  logic [15:0] m_tgt [WAYS][SETS];
  int          m_vp  [SETS];
  int          m_br, m_hit, m_mis;

  function automatic int sat(input int x);
    return (x >= MAXC) ? MAXC : x + 1;
  endfunction

  task automatic m_clear_entries();
    for (int s = 0; s < SETS; s++) begin
      m_vp[s] = 0;
      for (int w = 0; w < WAYS; w++) m_v[w][s] = 1'b0;
    end
  endtask

  task automatic m_reset();
    m_clear_entries();
    m_br = 0; m_hit = 0; m_mis = 0;
  endtask

  task automatic m_find(input logic [15:0] pc, output int way);
    int s;
    s = pc % SETS;
    way = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_v[w][s] && m_tag[w][s] == pc / SETS) way = w;
  endtask

  task automatic m_lookup(input logic [15:0] pc, output bit h, output bit p,
                          output logic [15:0] t);
    int w, s;
    s = pc % SETS;
    m_find(pc, w);
    h = (w >= 0);
    p = h && (m_ctr[w][s] >= 2);
    t = h ? m_tgt[w][s] : 16'h0;
  endtask

  task automatic m_update(input logic [15:0] pc, input bit tk, input logic [15:0] tg);
    int w, s;
    s = pc % SETS;
    m_find(pc, w);
    if (w >= 0) begin
      if (tk) begin
        m_ctr[w][s] = (m_ctr[w][s] == 3) ? 3 : m_ctr[w][s] + 1;
        m_tgt[w][s] = tg;
      end else begin
        m_ctr[w][s] = (m_ctr[w][s] == 0) ? 0 : m_ctr[w][s] - 1;
      end
    end else if (tk) begin
      for (int i = WAYS - 1; i >= 0; i--) if (!m_v[i][s]) w = i;
      if (w < 0) begin
        w = m_vp[s];
        m_vp[s] = (m_vp[s] + 1) % WAYS;
      end
      m_v[w][s]   = 1'b1;
      m_tag[w][s] = 8'(pc / SETS);
      m_ctr[w][s] = 2;
      m_tgt[w][s] = tg;
    end
  endtask

  // One clock of stimulus; the expected lookup response is queued for the monitor.
  task automatic cyc(input bit le, input logic [15:0] lp, input bit ue,
                     input logic [15:0] up, input bit ut, input logic [15:0] utg,
                     input bit upt, input bit fl);
    exp_t e;
    bit h, p, uh, up_p, mis;
    logic [15:0] t, ut_old;
    m_lookup(up, uh, up_p, ut_old);
    @(negedge clk);
    bus.lookup_en      = le;
    bus.lookup_pc      = lp;
    bus.upd_en         = ue;
    bus.upd_pc         = up;
    bus.upd_taken      = ut;
    bus.upd_target     = utg;
    bus.upd_hit        = uh;
    bus.upd_pred_taken = upt;
    bus.flush          = fl;
    if (le) begin
      m_lookup(lp, h, p, t);
      e.hit = h; e.pt = p; e.tgt = t; e.br = m_br; e.hc = m_hit; e.mc = m_mis;
      q.push_back(e);
      if (h) m_hit = sat(m_hit);
    end
    if (ue) begin
      m_br = sat(m_br);
      mis = (upt != ut) || (upt && ut && (!uh || ut_old != utg));
      if (mis) m_mis = sat(m_mis);
      if (!fl) m_update(up, ut, utg);
    end
    if (fl) m_clear_entries();
  endtask

  task automatic lk(input logic [15:0] pc);
    cyc(1'b1, pc, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [15:0] pc, input bit tk, input logic [15:0] tg,
                     input bit pt);
    cyc(1'b1, pc, 1'b1, pc, tk, tg, pt, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.lookup_en = 1'b0; bus.upd_en = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares whenever a lookup is presented, sampled mid low phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.lookup_en) begin
        if (q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          e = q.pop_front();
          chk("hit",         int'(bus.hit),         int'(e.hit));
          chk("pred_taken",  int'(bus.pred_taken),  int'(e.pt));
          chk("pred_target", int'(bus.pred_target), int'(e.tgt));
          chk("br_cnt",      int'(bus.br_cnt),      e.br);
          chk("hit_cnt",     int'(bus.hit_cnt),     e.hc);
          chk("mispr_cnt",   int'(bus.mispr_cnt),   e.mc);
        end
      end
    end
  end

  initial begin
    bit h, p;
    logic [15:0] t, pc, lpc;
    bus.lookup_en = 1'b0; bus.lookup_pc = '0;
    bus.upd_en = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0; bus.upd_target = '0;
    bus.upd_hit = 1'b0; bus.upd_pred_taken = 1'b0; bus.flush = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Reset state and first allocation
    lk(16'h0123);
    upd(16'h0123, 1'b1, 16'h0400, 1'b0);
    lk(16'h0123);
    lk(16'h0223);
    // Counter saturation up and down
    upd(16'h0123, 1'b1, 16'h0400, 1'b1);
    upd(16'h0123, 1'b1, 16'h0400, 1'b1);
    for (int i = 0; i < 4; i++) upd(16'h0123, 1'b0, 16'h0000, i == 0);
    lk(16'h0123);

    // Replacement: invalid-first, then round-robin
    do_reset();
    upd(16'h0010, 1'b1, 16'h1000, 1'b0);
    upd(16'h0110, 1'b1, 16'h1100, 1'b0);
    upd(16'h0210, 1'b1, 16'h1200, 1'b0);
    upd(16'h0310, 1'b1, 16'h1300, 1'b0);
    lk(16'h0010); lk(16'h0110); lk(16'h0210); lk(16'h0310);

    // Misprediction: wrong direction, then stale target
    upd(16'h0210, 1'b0, 16'h0000, 1'b1);
    upd(16'h0310, 1'b1, 16'h0500, 1'b1);
    upd(16'h0310, 1'b1, 16'h0400, 1'b1);
    lk(16'h0310);

    // Flush beats a simultaneous taken update
    cyc(1'b1, 16'h0310, 1'b1, 16'h0555, 1'b1, 16'h0777, 1'b0, 1'b1);
    lk(16'h0210); lk(16'h0310); lk(16'h0555);

    // hit_cnt saturation
    do_reset();
    upd(16'h0123, 1'b1, 16'h0400, 1'b0);
    repeat (21) lk(16'h0123);

    // rst during an update leaves nothing behind
    @(negedge clk);
    bus.lookup_en = 1'b0; bus.upd_en = 1'b1; bus.upd_pc = 16'h0777;
    bus.upd_taken = 1'b1; bus.upd_target = 16'h0abc; bus.flush = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    bus.upd_en = 1'b0;
    rst = 1'b0;
    m_reset();
    lk(16'h0777);

    // Randomized traffic on a few crowded sets
    do_reset();
    for (int n = 0; n < 600; n++) begin
      pc  = {8'($urandom_range(0, 5)), 8'($urandom_range(4, 6))};
      lpc = {8'($urandom_range(0, 5)), 8'($urandom_range(4, 6))};
      m_lookup(pc, h, p, t);
      if ($urandom_range(0, 99) < 5) p = ~p;
      cyc(($urandom_range(0, 99) < 80), lpc, ($urandom_range(0, 99) < 60), pc,
          ($urandom_range(0, 99) < 60), 16'($urandom_range(0, 3) * 16'h0100),
          p, ($urandom_range(0, 99) < 2));
      if (n % 150 == 149) do_reset();
    end

    @(negedge clk);
    bus.lookup_en = 1'b0; bus.upd_en = 1'b0; bus.flush = 1'b0;
    #4;
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
